// File: rtl/harmonic_sequencer_pkg.sv
// Shared definitions for the harmonic sequencer: FSM encoding and datapath widths/shifts.
package harmonic_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_READY,
    ST_SETTLE,
    ST_CAPTURE,
    ST_ADVANCE,
    ST_PUBLISH
  } state_t;

  localparam int ACC_W      = 24;
  localparam int MIX_W      = 16;
  localparam int GAIN_SHIFT = 8;
  localparam int OUT_SHIFT  = 4;

endpackage

// File: rtl/harmonic_sequencer_gain_mac.sv
// Gain multiply-accumulate and output scaling/saturation for the harmonic mixer.
// Purely combinational (zero latency); no backpressure, the caller decides when to register.
module harmonic_gain_mac
  import harmonic_sequencer_pkg::*;
(
  input  logic signed [15:0]      sample,
  input  logic        [7:0]       gain,
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] acc_sum,
  output logic signed [MIX_W-1:0] mix_sat
);

  localparam logic signed [ACC_W-1:0] MIX_MAX = 32767;
  localparam logic signed [ACC_W-1:0] MIX_MIN = -32768;

  logic signed [24:0]      product;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_scaled;

  // Gain is unsigned: a zero sign bit keeps 255 meaning 255/256 rather than -1/256.
  assign product    = sample * $signed({1'b0, gain});
  assign term       = ACC_W'(product >>> GAIN_SHIFT);
  assign acc_sum    = acc + term;
  assign acc_scaled = acc >>> OUT_SHIFT;

  always_comb begin
    mix_sat = acc_scaled[MIX_W-1:0];
    if (acc_scaled > MIX_MAX) begin
      mix_sat = 16'sh7FFF;
    end else if (acc_scaled < MIX_MIN) begin
      mix_sat = 16'sh8000;
    end
  end

endmodule

// File: rtl/harmonic_sequencer.sv
// Walks harmonics 0..count-1 per sample strobe, accumulating gain-weighted sine values into one mix sample.
// Per harmonic: WAIT_READY dwell + 3 cycles, then one PUBLISH cycle; strobes arriving while busy are dropped and flagged.
module harmonic_sequencer
  import harmonic_sequencer_pkg::*;
#(
  parameter int MAX_HARMONICS = 64
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Sample_Clock,
  input  logic [7:0]         i_Harmonic_Count,
  input  logic [7:0]         i_Odd_Gain,
  input  logic [7:0]         i_Even_Gain,
  input  logic               i_Sample_Ready,
  input  logic signed [15:0] i_Sample_Value,
  input  logic               i_Freq_Too_High,
  output logic [7:0]         o_Harmonic,
  output logic               o_Next_Sample,
  output logic signed [15:0] o_Mix,
  output logic               o_Mix_Valid,
  output logic               o_Busy,
  output logic               o_Overrun
);

  state_t                  state;
  logic [7:0]              count_q;
  logic                    last_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [MIX_W-1:0] mix_sat;
  logic [7:0]              count_clamped;
  logic [7:0]              gain;
  logic                    is_last;

  always_comb begin
    count_clamped = i_Harmonic_Count;
    if (i_Harmonic_Count == 8'd0) begin
      count_clamped = 8'd1;
    end else if (int'(i_Harmonic_Count) > MAX_HARMONICS) begin
      count_clamped = 8'(MAX_HARMONICS);
    end
  end

  assign gain    = o_Harmonic[0] ? i_Odd_Gain : i_Even_Gain;
  assign is_last = (o_Harmonic == count_q - 8'd1) || i_Freq_Too_High;

  harmonic_gain_mac u_mac (
    .sample  (i_Sample_Value),
    .gain    (gain),
    .acc     (acc),
    .acc_sum (acc_sum),
    .mix_sat (mix_sat)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state         <= ST_IDLE;
      count_q       <= 8'd0;
      last_q        <= 1'b0;
      acc           <= '0;
      o_Harmonic    <= 8'd0;
      o_Next_Sample <= 1'b0;
      o_Mix         <= '0;
      o_Mix_Valid   <= 1'b0;
      o_Busy        <= 1'b0;
      o_Overrun     <= 1'b0;
    end else begin
      o_Next_Sample <= 1'b0;
      o_Mix_Valid   <= 1'b0;
      // Includes the PUBLISH cycle, so a strobe racing the return to IDLE is dropped.
      if (i_Sample_Clock && state != ST_IDLE) begin
        o_Overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (i_Sample_Clock) begin
            count_q <= count_clamped;
            acc     <= '0;
            o_Busy  <= 1'b1;
            state   <= ST_WAIT_READY;
          end
        end
        ST_WAIT_READY: begin
          if (i_Sample_Ready) begin
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          acc           <= acc_sum;
          last_q        <= is_last;
          o_Next_Sample <= 1'b1;
          o_Harmonic    <= is_last ? 8'd0 : o_Harmonic + 8'd1;
          state         <= ST_ADVANCE;
        end
        ST_ADVANCE: state <= last_q ? ST_PUBLISH : ST_WAIT_READY;
        ST_PUBLISH: begin
          o_Mix       <= mix_sat;
          o_Mix_Valid <= 1'b1;
          o_Busy      <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          o_Busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Directed bench for harmonic_sequencer with a reactive sample-engine model and an arithmetic mix model.
module tb_harmonic_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               strobe = 1'b0;
  logic [7:0]         i_Harmonic_Count = 8'd0;
  logic [7:0]         odd_g = 8'd0;
  logic [7:0]         even_g = 8'd0;
  logic               rdy = 1'b0;
  logic signed [15:0] sval;
  logic               too_high;
  logic [7:0]         harm;
  logic               o_Next_Sample;
  logic signed [15:0] mix;
  logic               o_Mix_Valid;
  logic               o_Busy;
  logic               o_Overrun;

  logic signed [15:0] vals [64];
  int th_idx = 255;
  int eng_delay = 0;
  int wcnt = 0;
  int age = 0;
  int round_n = 0;
  int exp_q[$];
  int held_mix = 0;
  int ns_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  harmonic_sequencer dut (
    .i_Clock          (clk),
    .i_Reset          (rst),
    .i_Sample_Clock   (strobe),
    .i_Harmonic_Count (i_Harmonic_Count),
    .i_Odd_Gain       (odd_g),
    .i_Even_Gain      (even_g),
    .i_Sample_Ready   (rdy),
    .i_Sample_Value   (sval),
    .i_Freq_Too_High  (too_high),
    .o_Harmonic       (harm),
    .o_Next_Sample    (o_Next_Sample),
    .o_Mix            (mix),
    .o_Mix_Valid      (o_Mix_Valid),
    .o_Busy           (o_Busy),
    .o_Overrun        (o_Overrun)
  );

  // Engine: drops ready on each consumed harmonic; LUT data is junk until 2 cycles after ready rises.
  always @(posedge clk) begin
    if (rst || o_Next_Sample) begin
      rdy  <= 1'b0;
      wcnt <= eng_delay;
      age  <= 0;
    end else if (wcnt > 0) begin
      wcnt <= wcnt - 1;
    end else begin
      rdy <= 1'b1;
      if (rdy && age < 3) age <= age + 1;
    end
  end

  assign sval     = (rdy && age >= 2) ? vals[harm[5:0]] : 16'sh5A5A;
  assign too_high = (int'(harm) == th_idx);

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int model_n(input int cnt, input int th);
    int c;
    c = (cnt == 0) ? 1 : ((cnt > 64) ? 64 : cnt);
    return (th < c) ? th + 1 : c;
  endfunction

  function automatic int model_mix(input int cnt, input int odd, input int even, input int th);
    int n;
    int sum;
    int s;
    n = model_n(cnt, th);
    sum = 0;
    for (int h = 0; h < n; h++) begin
      sum += (int'(vals[h]) * (((h % 2) == 1) ? odd : even)) >>> 8;
    end
    s = sum >>> 4;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  // Every cycle: harmonic sequence on each consume pulse, mix value on publish, mix hold otherwise.
  always @(negedge clk) begin
    if (rst) begin
      ns_cnt   = 0;
      held_mix = 0;
    end else begin
      if (o_Next_Sample) begin
        ns_cnt++;
        check("next_harmonic", int'(harm), (ns_cnt == round_n) ? 0 : ns_cnt);
      end
      if (o_Mix_Valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_mix_valid", 1, 0);
        end else begin
          held_mix = exp_q.pop_front();
          check("mix_value", int'(mix), held_mix);
        end
        check("next_pulses", ns_cnt, round_n);
        ns_cnt = 0;
      end else begin
        check("mix_hold", int'(mix), held_mix);
      end
    end
  end

  // extra >= 0: second strobe that many cycles in; extra == -2: strobe in the PUBLISH cycle.
  task automatic run_round(input int cnt, input int odd, input int even, input int th,
                           input int dly, input int extra, output int got);
    bit done;
    bit pub_arm;
    done = 0;
    pub_arm = 0;
    got = 0;
    @(negedge clk);
    i_Harmonic_Count = 8'(cnt);
    odd_g     = 8'(odd);
    even_g    = 8'(even);
    th_idx    = th;
    eng_delay = dly;
    round_n   = model_n(cnt, th);
    exp_q.push_back(model_mix(cnt, odd, even, th));
    strobe = 1'b1;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      strobe = 1'b0;
      i_Harmonic_Count = 8'd1;
      if (cyc == extra || pub_arm) begin
        strobe  = 1'b1;
        pub_arm = 0;
      end
      if (extra == -2 && o_Next_Sample && harm == 8'd0) pub_arm = 1;
      if (o_Mix_Valid) begin
        got  = int'(mix);
        done = 1;
      end
    end
    if (!done) check("round_timeout", 0, 1);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 64; i++) vals[i] = 16'(v);
  endtask

  initial begin
    int got;
    bit found;
    fill(777);
    repeat (3) @(negedge clk);
    check("rst_harmonic", int'(harm), 0);
    check("rst_next", int'(o_Next_Sample), 0);
    check("rst_mix", int'(mix), 0);
    check("rst_mix_valid", int'(o_Mix_Valid), 0);
    check("rst_busy", int'(o_Busy), 0);
    check("rst_overrun", int'(o_Overrun), 0);
    rst = 1'b0;

    vals[0] = 16'sd16384;
    check("model_single", model_mix(1, 0, 255, 255), 1020);
    run_round(1, 0, 255, 255, 2, -1, got);
    check("single_mix", got, 1020);
    check("single_harm_zero", int'(harm), 0);

    fill(8000);
    check("model_even_only", model_mix(4, 0, 128, 255), 500);
    run_round(4, 0, 128, 255, 1, -1, got);
    check("even_only_mix", got, 500);

    fill(4096);
    check("model_too_high", model_mix(64, 64, 192, 5), 768);
    run_round(64, 64, 192, 5, 0, -1, got);
    check("too_high_mix", got, 768);

    fill(-1001);
    check("model_neg_round", model_mix(3, 255, 255, 255), -188);
    run_round(3, 255, 255, 255, 3, -1, got);
    check("neg_round_mix", got, -188);

    vals[0] = 16'sd3200;
    run_round(0, 255, 255, 255, 1, -1, got);
    check("count_zero_mix", got, 199);

    fill(32767);
    check("model_sat_pos", model_mix(64, 255, 255, 255), 32767);
    run_round(64, 255, 255, 255, 0, -1, got);
    check("sat_pos_mix", got, 32767);

    fill(-32768);
    run_round(200, 255, 255, 255, 0, -1, got);
    check("sat_neg_mix", got, -32768);

    fill(1000);
    check("overrun_before", int'(o_Overrun), 0);
    run_round(4, 128, 128, 255, 4, 10, got);
    check("overrun_mix", got, 125);
    check("overrun_set", int'(o_Overrun), 1);
    repeat (20) @(negedge clk);
    check("overrun_sticky", int'(o_Overrun), 1);

    // Abandon a round in WAIT_READY of harmonic 3.
    @(negedge clk);
    i_Harmonic_Count = 8'd8;
    eng_delay = 5;
    th_idx = 255;
    strobe = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 500 && !found; cyc++) begin
      @(negedge clk);
      strobe = 1'b0;
      if (harm == 8'd3 && !o_Next_Sample && o_Busy) found = 1;
    end
    check("abort_reached_h3", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_harmonic", int'(harm), 0);
    check("abort_next", int'(o_Next_Sample), 0);
    check("abort_mix", int'(mix), 0);
    check("abort_mix_valid", int'(o_Mix_Valid), 0);
    check("abort_busy", int'(o_Busy), 0);
    check("abort_overrun", int'(o_Overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_idle_harm", int'(harm), 0);
    check("abort_idle_busy", int'(o_Busy), 0);

    fill(0);
    vals[0] = 16'sd1600;
    vals[1] = 16'sd3200;
    run_round(2, 255, 255, 255, 2, -1, got);
    check("restart_mix", got, 298);
    check("restart_no_overrun", int'(o_Overrun), 0);

    run_round(1, 0, 255, 255, 1, -2, got);
    check("pub_edge_mix", got, 99);
    repeat (5) @(negedge clk);
    check("pub_edge_overrun", int'(o_Overrun), 1);
    check("pub_edge_idle", int'(o_Busy), 0);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
